// File: rtl/blake2_msg_tx.sv
// Message-side driver for the blake2 core: frames upstream bytes into zero-padded
// 64-byte blocks, holds off during compression, and forwards nn digest bytes.
module blake2_msg_tx #(
  parameter int LEN_W = 64,
  parameter int NN_W  = 7,
  parameter int F_CYC = 97
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic [NN_W-1:0]   nn_i,
  output logic              busy_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [7:0]        s_data_i,
  output logic              data_v_o,
  output logic [6:0]        data_idx_o,
  output logic [7:0]        data_o,
  output logic              block_first_o,
  output logic              block_last_o,
  output logic [NN_W-1:0]   kk_o,
  output logic [NN_W-1:0]   nn_o,
  output logic [127:0]      ll_o,
  input  logic              h_v_i,
  input  logic [7:0]        h_i,
  output logic              h_valid_o,
  output logic [7:0]        h_data_o,
  output logic              h_last_o
);
  localparam int WC_W = (F_CYC > 1) ? $clog2(F_CYC) : 1;

  // Upstream handshake: a byte moves on any cycle where s_valid_i and s_ready_o
  // are both high; s_ready_o is registered and only ever high in SEND.
  typedef enum logic [2:0] {IDLE, SEND, PAD, WAIT_F, WAIT_H} state_t;
  state_t state;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W:0]   blk_base;
  logic [LEN_W:0]   blk_end;
  logic [5:0]       idx;
  logic [WC_W-1:0]  wait_cnt;
  logic [NN_W-1:0]  out_cnt;
  logic             accept;

  assign accept  = s_valid_i && s_ready_o;
  assign blk_end = blk_base + (LEN_W+1)'(64);
  assign kk_o    = '0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      len           <= '0;
      byte_cnt      <= '0;
      blk_base      <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      out_cnt       <= '0;
      busy_o        <= 1'b0;
      s_ready_o     <= 1'b0;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      nn_o          <= '0;
      ll_o          <= '0;
      h_valid_o     <= 1'b0;
      h_data_o      <= '0;
      h_last_o      <= 1'b0;
    end else begin
      data_v_o  <= 1'b0;
      h_valid_o <= 1'b0;
      h_last_o  <= 1'b0;
      // Flags track blk_base, which only moves after idx 63, so they hold for a whole block.
      if (state != IDLE) begin
        block_first_o <= (blk_base == '0);
        block_last_o  <= ({1'b0, len} <= blk_end);
      end
      case (state)
        IDLE: begin
          block_first_o <= 1'b0;
          block_last_o  <= 1'b0;
          if (start_i) begin
            len           <= msg_len_i;
            nn_o          <= nn_i;
            ll_o          <= {{(128-LEN_W){1'b0}}, msg_len_i};
            byte_cnt      <= '0;
            blk_base      <= '0;
            idx           <= '0;
            wait_cnt      <= '0;
            out_cnt       <= '0;
            busy_o        <= 1'b1;
            block_first_o <= 1'b1;
            block_last_o  <= ({1'b0, msg_len_i} <= (LEN_W+1)'(64));
            if (msg_len_i == '0) begin
              state <= PAD;
            end else begin
              state     <= SEND;
              s_ready_o <= 1'b1;
            end
          end
        end
        SEND: begin
          if (accept) begin
            data_v_o   <= 1'b1;
            data_o     <= s_data_i;
            data_idx_o <= {1'b0, idx};
            idx        <= idx + 6'd1;
            byte_cnt   <= byte_cnt + LEN_W'(1);
            if (idx == 6'd63) begin
              s_ready_o <= 1'b0;
              blk_base  <= blk_end;
              wait_cnt  <= '0;
              state     <= WAIT_F;
            end else if (byte_cnt + LEN_W'(1) == len) begin
              s_ready_o <= 1'b0;
              state     <= PAD;
            end
          end
        end
        PAD: begin
          data_v_o   <= 1'b1;
          data_o     <= 8'h00;
          data_idx_o <= {1'b0, idx};
          idx        <= idx + 6'd1;
          if (idx == 6'd63) begin
            blk_base <= blk_end;
            wait_cnt <= '0;
            state    <= WAIT_F;
          end
        end
        WAIT_F: begin
          // blk_base already points past the finished block here.
          if (wait_cnt == WC_W'(F_CYC-1)) begin
            if ({1'b0, len} <= blk_base) begin
              state <= WAIT_H;
            end else begin
              state     <= SEND;
              s_ready_o <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        WAIT_H: begin
          if (h_v_i) begin
            if (out_cnt < nn_o) begin
              h_valid_o <= 1'b1;
              h_data_o  <= h_i;
              h_last_o  <= (out_cnt == nn_o - NN_W'(1));
              out_cnt   <= out_cnt + NN_W'(1);
            end
          end else if (out_cnt == nn_o) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blake2_msg_tx.sv
// Bench for blake2_msg_tx: drives framed messages, plays the core's digest stream,
// and scoreboards block bytes and forwarded digest bytes.
module tb_blake2_msg_tx;
  localparam int LEN_W = 64;
  localparam int NN_W  = 7;
  localparam int F_CYC = 97;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  msg_len_i = '0;
  logic [NN_W-1:0]   nn_i = '0;
  logic              busy_o;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [7:0]        s_data_i = '0;
  logic              data_v_o;
  logic [6:0]        data_idx_o;
  logic [7:0]        data_o;
  logic              block_first_o;
  logic              block_last_o;
  logic [NN_W-1:0]   kk_o;
  logic [NN_W-1:0]   nn_o;
  logic [127:0]      ll_o;
  logic              h_v_i = 1'b0;
  logic [7:0]        h_i = '0;
  logic              h_valid_o;
  logic [7:0]        h_data_o;
  logic              h_last_o;

  blake2_msg_tx #(.LEN_W(LEN_W), .NN_W(NN_W), .F_CYC(F_CYC)) dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .msg_len_i(msg_len_i), .nn_i(nn_i),
    .busy_o(busy_o), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o), .kk_o(kk_o), .nn_o(nn_o),
    .ll_o(ll_o), .h_v_i(h_v_i), .h_i(h_i), .h_valid_o(h_valid_o), .h_data_o(h_data_o),
    .h_last_o(h_last_o)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];   // {first, last, idx, data}
  logic [8:0]  hexp_q[$];  // {last, data}
  logic [7:0]  msg_q[$];
  logic [7:0]  dig_pre[$];
  int total = 0;
  int bad = 0;
  int gap_cnt = 0;
  int last_gap = -1;
  int ready_early = 0;
  bit counting = 0;
  bit ready_ever = 0;
  logic [16:0] blk_got, blk_exp;
  logic [8:0]  h_got, h_exp;

  // Scoreboard: pops expected block bytes / digest bytes as the DUT emits them.
  always @(negedge clk) begin
    if (nreset) begin
      if (s_ready_o) ready_ever = 1;
      if (data_v_o) begin
        blk_got = {block_first_o, block_last_o, data_idx_o, data_o};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL blk_extra got=%h exp=none", blk_got);
        end else begin
          blk_exp = exp_q.pop_front();
          if (blk_got !== blk_exp) begin
            bad++;
            $display("FAIL blk_byte got=%h exp=%h", blk_got, blk_exp);
          end
        end
        if (counting) begin
          last_gap = gap_cnt;
          counting = 0;
        end
        if (data_idx_o == 7'd63) begin
          counting = 1;
          gap_cnt = 0;
        end
      end else if (counting) begin
        if (gap_cnt < F_CYC-1 && s_ready_o) ready_early++;
        gap_cnt++;
      end
      if (h_valid_o) begin
        h_got = {h_last_o, h_data_o};
        total++;
        if (hexp_q.size() == 0) begin
          bad++;
          $display("FAIL digest_extra got=%h exp=none", h_got);
        end else begin
          h_exp = hexp_q.pop_front();
          if (h_got !== h_exp) begin
            bad++;
            $display("FAIL digest_byte got=%h exp=%h", h_got, h_exp);
          end
        end
      end
    end
  end

  task automatic fill_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic build_exp();
    int len;
    int total_b;
    logic [7:0] d;
    len = msg_q.size();
    total_b = (len == 0) ? 64 : ((len + 63) / 64) * 64;
    for (int p = 0; p < total_b; p++) begin
      d = (p < len) ? msg_q[p] : 8'h00;
      exp_q.push_back({(p < 64) ? 1'b1 : 1'b0, (p >= total_b - 64) ? 1'b1 : 1'b0, 7'(p % 64), d});
    end
  endtask

  task automatic start_msg(input int len, input int nn);
    counting = 0;
    ready_early = 0;
    ready_ever = 0;
    last_gap = -1;
    @(posedge clk); #1;
    start_i = 1'b1;
    msg_len_i = LEN_W'(len);
    nn_i = NN_W'(nn);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int upto, input bit gap);
    int sent = 0;
    int cyc = 0;
    bit fire;
    bit tog = 1'b1;
    while (sent < upto && cyc < 2000) begin
      s_valid_i = gap ? tog : 1'b1;
      s_data_i = msg_q[sent];
      @(negedge clk);
      fire = s_valid_i && s_ready_o;
      @(posedge clk); #1;
      if (fire) sent++;
      tog = ~tog;
      cyc++;
    end
    s_valid_i = 1'b0;
    total++;
    if (sent != upto) begin
      bad++;
      $display("FAIL feed_timeout sent=%0d need=%0d", sent, upto);
    end
  endtask

  task automatic wait_blocks();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL blocks_timeout left=%0d need=0", exp_q.size());
    end
  endtask

  task automatic core_digest(input int nn);
    logic [7:0] b;
    repeat (F_CYC + 8) @(posedge clk);
    #1;
    for (int i = 0; i <= nn; i++) begin
      b = (i < dig_pre.size()) ? dig_pre[i] : 8'($urandom_range(0, 255));
      h_v_i = 1'b1;
      h_i = b;
      if (i < nn) hexp_q.push_back({(i == nn - 1) ? 1'b1 : 1'b0, b});
      @(posedge clk); #1;
    end
    h_v_i = 1'b0;
    h_i = 8'h00;
    dig_pre.delete();
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy_o !== 1'b0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_timeout got=%b exp=0", busy_o);
    end
    total++;
    if (hexp_q.size() != 0) begin
      bad++;
      $display("FAIL digest_missing left=%0d need=0", hexp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy_o, s_ready_o, data_v_o, block_first_o, block_last_o, h_valid_o, h_last_o,
         data_idx_o, data_o, h_data_o, nn_o, ll_o, kk_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b rdy=%b v=%b ll=%h nn=%h", busy_o, s_ready_o, data_v_o, ll_o, nn_o);
    end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_abc();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    build_exp();
    start_msg(3, 64);
    total++;
    if (busy_o !== 1'b1 || ll_o !== 128'd3 || nn_o !== 7'd64 || kk_o !== 7'd0) begin
      bad++;
      $display("FAIL abc_capture busy=%b ll=%0d nn=%0d kk=%0d exp 1/3/64/0", busy_o, ll_o, nn_o, kk_o);
    end
    feed(3, 1'b0);
    wait_blocks();
    dig_pre = '{8'hBA, 8'h80, 8'hA5, 8'h3F, 8'h98, 8'h1C, 8'h4D, 8'h0D};
    core_digest(64);
    wait_idle();
  endtask

  task automatic test_empty();
    msg_q.delete();
    build_exp();
    start_msg(0, 64);
    total++;
    if (ll_o !== 128'd0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL empty_capture ll=%0d busy=%b exp 0/1", ll_o, busy_o);
    end
    wait_blocks();
    total++;
    if (ready_ever !== 1'b0) begin
      bad++;
      $display("FAIL empty_ready got=%b exp=0", ready_ever);
    end
    dig_pre = '{8'h78, 8'h6A, 8'h02, 8'hF7, 8'h42, 8'h01, 8'h59, 8'h03};
    core_digest(64);
    wait_idle();
  endtask

  task automatic test_len65();
    fill_random(65);
    build_exp();
    start_msg(65, 64);
    total++;
    if (ll_o !== 128'd65) begin
      bad++;
      $display("FAIL len65_ll got=%0d exp=65", ll_o);
    end
    feed(65, 1'b0);
    wait_blocks();
    total++;
    if (last_gap != F_CYC) begin
      bad++;
      $display("FAIL len65_gap got=%0d exp=%0d", last_gap, F_CYC);
    end
    total++;
    if (ready_early != 0) begin
      bad++;
      $display("FAIL len65_ready_in_wait got=%0d exp=0", ready_early);
    end
    core_digest(64);
    wait_idle();
  endtask

  task automatic test_len128_gap();
    fill_random(128);
    build_exp();
    start_msg(128, 48);
    feed(128, 1'b1);
    wait_blocks();
    total++;
    if (last_gap < F_CYC) begin
      bad++;
      $display("FAIL len128_gap got=%0d exp>=%0d", last_gap, F_CYC);
    end
    total++;
    if (ready_early != 0) begin
      bad++;
      $display("FAIL len128_ready_in_wait got=%0d exp=0", ready_early);
    end
    core_digest(48);
    wait_idle();
  endtask

  task automatic test_nn32_ignore_start();
    fill_random(100);
    build_exp();
    start_msg(100, 32);
    start_i = 1'b1;
    msg_len_i = LEN_W'(5);
    nn_i = NN_W'(9);
    @(posedge clk); #1;
    start_i = 1'b0;
    total++;
    if (ll_o !== 128'd100 || nn_o !== 7'd32 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL ignore_start ll=%0d nn=%0d busy=%b exp 100/32/1", ll_o, nn_o, busy_o);
    end
    feed(100, 1'b0);
    wait_blocks();
    core_digest(32);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL nn32_busy_early got=%b exp=1", busy_o);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    fill_random(40);
    build_exp();
    start_msg(40, 16);
    feed(21, 1'b0);
    @(negedge clk); #1;
    nreset = 1'b0;
    #1;
    total++;
    if ({busy_o, s_ready_o, data_v_o, block_first_o, block_last_o, h_valid_o, h_last_o,
         data_idx_o, data_o, h_data_o, nn_o, ll_o} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs busy=%b rdy=%b v=%b idx=%0d ll=%h", busy_o, s_ready_o, data_v_o, data_idx_o, ll_o);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    fill_random(10);
    build_exp();
    start_msg(10, 16);
    total++;
    if (ll_o !== 128'd10 || nn_o !== 7'd16) begin
      bad++;
      $display("FAIL midreset_restart ll=%0d nn=%0d exp 10/16", ll_o, nn_o);
    end
    feed(10, 1'b0);
    wait_blocks();
    core_digest(16);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len65();
    test_len128_gap();
    test_nn32_ignore_start();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blake2_msg_tx.md
Name: blake2_msg_tx

Overview:
- Message-side driver for the blake2 core (default blake2b, W=64).
- Takes a length-prefixed byte stream from upstream with valid/ready handshake.
- Produces the core's byte-indexed block interface: zero-pads the final block, drives first/last block flags and total length, and enforces the core's compression busy window.
- Captures the digest bytes streamed back by the core and forwards exactly nn of them, tagged with a last marker.

Parameters:
- LEN_W, 64, width of message byte-length counter; zero-extended to 128-bit ll_o.
- NN_W, 7, width of digest length fields; matches core kk/nn width.
- F_CYC, 97, idle cycles required after byte idx 63 before next byte (R*8+1, R=12).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- start_i  in  1  pulse: begin message; sampled only when busy_o=0
- msg_len_i  in  LEN_W  message length in bytes, captured on start_i
- nn_i  in  NN_W  digest length in bytes (1..64), captured on start_i
- busy_o  out  1  high from accepted start_i until the last digest byte is forwarded
- s_valid_i  in  1  upstream byte valid
- s_ready_o  out  1  upstream byte ready
- s_data_i  in  8  upstream message byte
- data_v_o  out  1  byte valid to core
- data_idx_o  out  7  byte index within block, 0..63
- data_o  out  8  byte to core
- block_first_o  out  1  current block is block 0
- block_last_o  out  1  current block is final block
- kk_o  out  NN_W  key length; constant 0 (unkeyed)
- nn_o  out  NN_W  captured nn
- ll_o  out  128  captured msg_len, zero-extended
- h_v_i  in  1  digest byte valid from core
- h_i  in  8  digest byte from core
- h_valid_o  out  1  forwarded digest byte valid
- h_data_o  out  8  forwarded digest byte
- h_last_o  out  1  marks the nn-th digest byte

Behaviour:
- Reset (asynchronous, nreset=0) puts the FSM in IDLE and clears all counters.
- Output reset values: busy_o, s_ready_o, data_v_o, block_first_o, block_last_o, h_valid_o and h_last_o are 0. data_idx_o, data_o, h_data_o, nn_o, ll_o and kk_o are 0.
- Reset mid-message abandons the message. The core must be reset alongside this block.
- All outputs are registered. nn_o and ll_o hold stable from start until return to IDLE.
- FSM states: IDLE, SEND, PAD, WAIT_F, WAIT_H.
- IDLE:
  - On start_i, capture len/nn, clear byte_cnt, idx, blk_base; busy_o<=1.
  - If len=0, go to PAD; otherwise go to SEND.
- SEND:
  - s_ready_o=1 while byte_cnt<len and WAIT_F is not active.
  - On s_valid_i&s_ready_o, emit data_v_o=1 with data_o=s_data_i and data_idx_o=idx the next cycle; increment idx (mod 64) and byte_cnt.
  - Upstream gaps produce data_v_o=0 cycles; the core tolerates these.
  - When byte_cnt reaches len: if idx≠0, go to PAD.
- PAD: emit zero bytes with data_v_o=1 on consecutive cycles until idx 63 is emitted.
- After any emission with idx=63:
  - blk_base += 64; enter WAIT_F; data_v_o=0 for exactly F_CYC cycles (wait counter).
  - Then: if the block was last, go to WAIT_H; else return to SEND.
  - s_ready_o=0 throughout WAIT_F.
- Block flags, held on every byte of the block:
  - block_first_o = (blk_base==0).
  - block_last_o = (len ≤ blk_base+64), computed with LEN_W+1 bits to avoid overflow.
  - len=0 produces one all-zero block with first=last=1 and ll_o=0.
- WAIT_H:
  - Each h_v_i with out_cnt<nn: h_valid_o=1, h_data_o=h_i, out_cnt++. h_last_o=1 when out_cnt==nn-1.
  - Core bytes beyond nn are dropped. The core emits nn+1 bytes; the extra one is discarded.
  - After h_last_o, wait for h_v_i=0, then go to IDLE with busy_o=0.
- start_i while busy_o=1 is ignored.
- s_valid_i in IDLE/PAD/WAIT_H is not accepted (s_ready_o=0).
- Byte counter never wraps: len ≤ 2^LEN_W-1.

Test Plan:
- "abc": start len=3, nn=64, bytes 61 62 63 -> one block (idx 0-2 data, 3-63 zero), first=last=1, ll_o=3. Digest starts BA 80 A5 3F 98 1C 4D 0D. h_last_o on byte 64; 65th core byte dropped.
- Empty message: start len=0, nn=64 -> 64 zero bytes, first=last=1, ll_o=0, s_ready_o never 1. Digest starts 78 6A 02 F7 42 01 59 03.
- len=65 -> block0: idx 0-63 data, first=1, last=0. Then exactly 97 cycles of data_v_o=0. Block1: 1 data byte + 63 zero pad, first=0, last=1. ll_o=65.
- len=128 with s_valid_i toggling every other cycle -> no padding; data_v_o gaps mirror upstream; s_ready_o=0 during WAIT_F. Last flag only on block1.
- nn=32 -> exactly 32 h_valid_o pulses with h_last_o on the 32nd. busy_o falls after h_v_i drops. A start_i pulsed mid-message is ignored.
- Assert nreset mid-SEND (idx=20) -> all outputs go to 0 immediately. A new start_i after release runs a clean message from idx 0.
